// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline types and constants for the fetch stage
// and the IF/ID bundle consumed by decode.
package if_fetch_stage_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam int PC_STEP = 4;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HELD  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic            valid;
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
   } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if_id_latch.sv
// IF/ID pipeline register: flush beats load, otherwise holds.
// Flush only clears valid/instr; the address fields keep their value.
module if_id_latch #(
   parameter int ADDR_W = 32,
   parameter int INSTR_W = 32,
   parameter logic [INSTR_W-1:0] NOP = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               flush,
   input  logic [INSTR_W-1:0] d_instr,
   input  logic [ADDR_W-1:0]  d_pc,
   input  logic [ADDR_W-1:0]  d_pc_plus4,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  pc_plus4
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid    <= 1'b0;
         instr    <= NOP;
         pc       <= '0;
         pc_plus4 <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= NOP;
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= d_instr;
         pc       <= d_pc;
         pc_plus4 <= d_pc_plus4;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: imem handshake, next-PC select, one-entry
// skid for data arriving under stall, and the IF/ID latch.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int ADDR_W = XLEN,
   parameter int INSTR_W = ILEN,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_WORD)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic [ADDR_W-1:0]  pc_next,
   output logic               pc_ena,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [ADDR_W-1:0]  if_id_pc_plus4
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

   fetch_state_e       state, state_n;
   logic [ADDR_W-1:0]  req_addr, cur_addr, tgt;
   logic [ADDR_W-1:0]  skid_pc, d_pc;
   logic [INSTR_W-1:0] skid_instr, d_instr;
   logic               ena_c, ld, fl, skid_ld;

   always_comb begin
      cur_addr = (state == S_FETCH) ? pc_in : req_addr;
      tgt      = redirect_pc & ALIGN;
      state_n  = state;
      pc_next  = pc_in;
      ena_c    = 1'b0;
      ld       = 1'b0;
      fl       = 1'b0;
      skid_ld  = 1'b0;
      d_instr  = imem_rdata;
      d_pc     = cur_addr;
      unique case (state)
         S_FETCH, S_WAIT: begin
            if (redirect_valid) begin
               pc_next = tgt;
               ena_c   = 1'b1;
               fl      = 1'b1;
               state_n = imem_ready ? S_FETCH : S_DRAIN;
            end else if (imem_ready && !stall) begin
               ld      = 1'b1;
               pc_next = cur_addr + STEP;
               ena_c   = 1'b1;
               state_n = S_FETCH;
            end else if (imem_ready) begin
               skid_ld = 1'b1;
               state_n = S_HELD;
            end else begin
               fl      = !stall;
               state_n = S_WAIT;
            end
         end
         S_HELD: begin
            d_instr = skid_instr;
            d_pc    = skid_pc;
            if (redirect_valid) begin
               pc_next = tgt;
               ena_c   = 1'b1;
               fl      = 1'b1;
               state_n = S_FETCH;
            end else if (!stall) begin
               ld      = 1'b1;
               pc_next = skid_pc + STEP;
               ena_c   = 1'b1;
               state_n = S_FETCH;
            end
         end
         S_DRAIN: begin
            // stale response in flight: keep IF/ID empty until it lands
            fl = 1'b1;
            if (redirect_valid) begin
               pc_next = tgt;
               ena_c   = 1'b1;
            end
            if (imem_ready) state_n = S_FETCH;
         end
         default: state_n = S_FETCH;
      endcase
   end

   assign imem_req  = (state != S_HELD);
   assign imem_addr = cur_addr;
   assign pc_ena    = ena_c & rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_FETCH;
         req_addr   <= '0;
         skid_instr <= NOP_INSTR;
         skid_pc    <= '0;
      end else begin
         state <= state_n;
         if (state == S_FETCH) req_addr <= pc_in;
         if (skid_ld) begin
            skid_instr <= imem_rdata;
            skid_pc    <= cur_addr;
         end
      end
   end

   if_id_latch #(
      .ADDR_W (ADDR_W),
      .INSTR_W(INSTR_W),
      .NOP    (NOP_INSTR)
   ) u_if_id (
      .clk       (clk),
      .rst       (rst),
      .load      (ld),
      .flush     (fl),
      .d_instr   (d_instr),
      .d_pc      (d_pc),
      .d_pc_plus4(d_pc + STEP),
      .valid     (if_id_valid),
      .instr     (if_id_instr),
      .pc        (if_id_pc),
      .pc_plus4  (if_id_pc_plus4)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vector bench for if_fetch_stage with a PC register
// and an address-keyed instruction memory around the DUT.
module tb_if_fetch_stage;

   localparam bit H = 1'b1;
   localparam bit L = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_reg = '0;
   logic [31:0] pc_next, imem_addr, imem_rdata, redirect_pc;
   logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
   logic        pc_ena, imem_req, imem_ready, stall;
   logic        redirect_valid, if_id_valid;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit        rdy, stl, rv;
      bit [31:0] rpc;
      bit        req;
      bit [31:0] addr;
      bit        ena;
      bit [31:0] nxt;
      bit        v;
      bit [31:0] ins, pc, p4;
   } vec_t;

   vec_t tv[$];

   always #5 clk = ~clk;

   always @(posedge clk) if (pc_ena) pc_reg <= pc_next;

   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   if_fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .pc_in         (pc_reg),
      .pc_next       (pc_next),
      .pc_ena        (pc_ena),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .if_id_valid   (if_id_valid),
      .if_id_instr   (if_id_instr),
      .if_id_pc      (if_id_pc),
      .if_id_pc_plus4(if_id_pc_plus4)
   );

   function automatic vec_t mk(
      input bit rdy, stl, rv, input bit [31:0] rpc,
      input bit req, input bit [31:0] addr,
      input bit ena, input bit [31:0] nxt,
      input bit v, input bit [31:0] ins, pc, p4);
      vec_t t;
      t.rdy = rdy; t.stl = stl; t.rv = rv; t.rpc = rpc;
      t.req = req; t.addr = addr; t.ena = ena; t.nxt = nxt;
      t.v = v; t.ins = ins; t.pc = pc; t.p4 = p4;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit rdy, stl, rv, input bit [31:0] rpc);
      imem_ready     = rdy;
      stall          = stl;
      redirect_valid = rv;
      redirect_pc    = rpc;
   endtask

   initial begin
      drive(L, L, L, 32'h0);
      // streaming, wait states, stall/skid, redirect, drain, wrap
      tv.push_back(mk(H,L,L,0, H,32'h0,  H,32'h4,  L,0,0,0));
      tv.push_back(mk(H,L,L,0, H,32'h4,  H,32'h8,  H,32'hA5A5_0000,32'h0,32'h4));
      tv.push_back(mk(H,L,L,0, H,32'h8,  H,32'hC,  H,32'hA5A5_0004,32'h4,32'h8));
      tv.push_back(mk(H,L,L,0, H,32'hC,  H,32'h10, H,32'hA5A5_0008,32'h8,32'hC));
      tv.push_back(mk(L,L,L,0, H,32'h10, L,0,      H,32'hA5A5_000C,32'hC,32'h10));
      tv.push_back(mk(L,L,L,0, H,32'h10, L,0,      L,0,0,0));
      tv.push_back(mk(L,L,L,0, H,32'h10, L,0,      L,0,0,0));
      tv.push_back(mk(H,L,L,0, H,32'h10, H,32'h14, L,0,0,0));
      tv.push_back(mk(H,L,L,0, H,32'h14, H,32'h18, H,32'hA5A5_0010,32'h10,32'h14));
      tv.push_back(mk(H,L,L,0, H,32'h18, H,32'h1C, H,32'hA5A5_0014,32'h14,32'h18));
      tv.push_back(mk(H,L,L,0, H,32'h1C, H,32'h20, H,32'hA5A5_0018,32'h18,32'h1C));
      tv.push_back(mk(H,H,L,0, H,32'h20, L,0,      H,32'hA5A5_001C,32'h1C,32'h20));
      tv.push_back(mk(H,H,L,0, L,0,      L,0,      H,32'hA5A5_001C,32'h1C,32'h20));
      tv.push_back(mk(L,L,L,0, L,0,      H,32'h24, H,32'hA5A5_001C,32'h1C,32'h20));
      tv.push_back(mk(H,L,L,0, H,32'h24, H,32'h28, H,32'hA5A5_0020,32'h20,32'h24));
      tv.push_back(mk(H,L,H,32'h42, H,32'h28, H,32'h40, H,32'hA5A5_0024,32'h24,32'h28));
      tv.push_back(mk(L,L,L,0, H,32'h40, L,0,      L,0,0,0));
      tv.push_back(mk(L,L,H,32'h103, H,32'h40, H,32'h100, L,0,0,0));
      tv.push_back(mk(L,L,L,0, H,32'h40, L,0,      L,0,0,0));
      tv.push_back(mk(H,L,L,0, H,32'h40, L,0,      L,0,0,0));
      tv.push_back(mk(H,L,L,0, H,32'h100, H,32'h104, L,0,0,0));
      tv.push_back(mk(L,H,L,0, H,32'h104, L,0,     H,32'hA5A5_0100,32'h100,32'h104));
      tv.push_back(mk(H,H,L,0, H,32'h104, L,0,     H,32'hA5A5_0100,32'h100,32'h104));
      tv.push_back(mk(L,H,H,32'hFFFF_FFFD, L,0, H,32'hFFFF_FFFC,
                      H,32'hA5A5_0100,32'h100,32'h104));
      tv.push_back(mk(H,L,L,0, H,32'hFFFF_FFFC, H,32'h0, L,0,0,0));
      tv.push_back(mk(L,L,L,0, H,32'h0, L,0,
                      H,32'h5A5A_FFFC,32'hFFFF_FFFC,32'h0));

      #1 rst = 1'b0;
      #2;
      chk("rst valid", {31'd0, if_id_valid}, 32'd0);
      chk("rst instr", if_id_instr, 32'h0);
      chk("rst pc", if_id_pc, 32'h0);
      chk("rst pc4", if_id_pc_plus4, 32'h0);
      chk("rst req", {31'd0, imem_req}, 32'd1);
      chk("rst ena", {31'd0, pc_ena}, 32'd0);
      @(posedge clk);
      #2 rst = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         drive(tv[i].rdy, tv[i].stl, tv[i].rv, tv[i].rpc);
         #1;
         chk($sformatf("r%0d req", i), {31'd0, imem_req}, {31'd0, tv[i].req});
         if (tv[i].req)
            chk($sformatf("r%0d addr", i), imem_addr, tv[i].addr);
         chk($sformatf("r%0d ena", i), {31'd0, pc_ena}, {31'd0, tv[i].ena});
         if (tv[i].ena)
            chk($sformatf("r%0d next", i), pc_next, tv[i].nxt);
         chk($sformatf("r%0d valid", i), {31'd0, if_id_valid}, {31'd0, tv[i].v});
         chk($sformatf("r%0d instr", i), if_id_instr, tv[i].ins);
         if (tv[i].v) begin
            chk($sformatf("r%0d pc", i), if_id_pc, tv[i].pc);
            chk($sformatf("r%0d pc4", i), if_id_pc_plus4, tv[i].p4);
         end
      end

      // reset pulled low while waiting with a valid IF/ID entry
      @(negedge clk);
      drive(H, L, L, 32'h0);
      #1 chk("mr fetch0 next", pc_next, 32'h4);
      @(negedge clk);
      drive(L, H, L, 32'h0);
      #1 chk("mr wait valid", {31'd0, if_id_valid}, 32'd1);
      chk("mr wait addr", imem_addr, 32'h4);
      @(negedge clk);
      drive(L, L, L, 32'h0);
      #1 rst = 1'b0;
      #1;
      chk("mr valid", {31'd0, if_id_valid}, 32'd0);
      chk("mr instr", if_id_instr, 32'h0);
      chk("mr pc", if_id_pc, 32'h0);
      chk("mr pc4", if_id_pc_plus4, 32'h0);
      chk("mr req", {31'd0, imem_req}, 32'd1);
      chk("mr ena", {31'd0, pc_ena}, 32'd0);
      chk("mr addr", imem_addr, 32'h4);
      @(negedge clk);
      rst = 1'b1;
      drive(H, L, L, 32'h0);
      #1;
      chk("rel addr", imem_addr, 32'h4);
      chk("rel ena", {31'd0, pc_ena}, 32'd1);
      chk("rel next", pc_next, 32'h8);
      chk("rel valid", {31'd0, if_id_valid}, 32'd0);
      @(negedge clk);
      drive(L, L, L, 32'h0);
      #1;
      chk("rel2 valid", {31'd0, if_id_valid}, 32'd1);
      chk("rel2 instr", if_id_instr, 32'hA5A5_0004);
      chk("rel2 pc", if_id_pc, 32'h4);
      chk("rel2 pc4", if_id_pc_plus4, 32'h8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
